// File: rtl/retreo_pkg.sv
// Shared ReTReO definitions: register width and default output-FIFO sizing.
package retreo_pkg;

   localparam int unsigned WORD_W           = 16;
   localparam int unsigned FIFO_DEPTH_DEF   = 8;
   localparam int unsigned STALL_MARGIN_DEF = 2;

   typedef logic [WORD_W-1:0] word_t;

endpackage

// File: rtl/retreo_out_fifo_if.sv
// Valid/ready read port of the ReTReO output FIFO.
// The master is the FIFO and drives data and valid. The slave is the reader.
interface retreo_out_fifo_if
   import retreo_pkg::*;
   ();

   logic  Rd_Valid;
   logic  Rd_Ready;
   word_t Rd_Data;

   modport master (output Rd_Valid, output Rd_Data, input  Rd_Ready);
   modport slave  (input  Rd_Valid, input  Rd_Data, output Rd_Ready);

endinterface

// File: rtl/retreo_sync_fifo.sv
// First-word-fall-through synchronous FIFO.
// Full and empty are told apart by the occupancy count rather than by comparing pointers.
// The head entry is presented combinationally from registered state.
module retreo_sync_fifo
   import retreo_pkg::*;
   #(
      parameter int unsigned DEPTH  = FIFO_DEPTH_DEF,
      parameter int unsigned ADDR_W = $clog2(DEPTH)
   )
   (
      input  logic            clk,
      input  logic            rst,
      input  logic            i_wr,
      input  word_t           i_wr_data,
      input  logic            i_rd,
      output word_t           o_rd_data,
      output logic            o_valid,
      output logic [ADDR_W:0] o_count,
      output logic [ADDR_W:0] o_count_next
   );

   word_t             r_mem [DEPTH];
   logic [ADDR_W-1:0] r_wr_ptr;
   logic [ADDR_W-1:0] r_rd_ptr;
   logic [ADDR_W:0]   r_count;
   logic              w_rd;
   logic [ADDR_W:0]   w_count_next;

   // A read is honoured only when an entry exists, so the count never underflows.
   always_comb begin
      w_rd         = i_rd & (r_count != '0);
      w_count_next = r_count;
      if (i_wr && !w_rd)
         w_count_next = r_count + 1'b1;
      else if (!i_wr && w_rd)
         w_count_next = r_count - 1'b1;
   end

   // Pointer and occupancy registers. The pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (i_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
         r_count <= w_count_next;
      end
   end

   // Storage array. It is deliberately left uncleared by reset.
   always_ff @(posedge clk) begin
      if (i_wr) r_mem[r_wr_ptr] <= i_wr_data;
   end

   assign o_rd_data    = r_mem[r_rd_ptr];
   assign o_valid      = (r_count != '0);
   assign o_count      = r_count;
   assign o_count_next = w_count_next;

endmodule

// File: rtl/retreo_out_fifo.sv
// ReTReO output capture.
// Each change of Out_Reg is queued into a FWFT FIFO for a valid/ready reader.
// Stall_Req asks the core to halt before the queue overflows.
// If a change arrives while the FIFO is full and not being read, it is dropped and Overflow is latched.
module retreo_out_fifo
   import retreo_pkg::*;
   #(
      parameter int unsigned DEPTH        = FIFO_DEPTH_DEF,
      parameter int unsigned ADDR_W       = $clog2(DEPTH),
      parameter int unsigned STALL_MARGIN = STALL_MARGIN_DEF
   )
   (
      input  logic                     clk,
      input  logic                     rst,
      input  word_t                    Out_Reg_In,
      output logic                     Stall_Req,
      retreo_out_fifo_if.master        rd_if,
      output logic [ADDR_W:0]          Count,
      output logic                     Overflow
   );

   localparam logic [ADDR_W:0] C_DEPTH  = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] C_THRESH = (ADDR_W+1)'(DEPTH - STALL_MARGIN);

   word_t           r_last_val;
   logic            r_stall;
   logic            r_overflow;
   logic            w_chg;
   logic            w_rd;
   logic            w_wr;
   logic            w_full;
   logic            w_drop;
   logic [ADDR_W:0] w_count;
   logic [ADDR_W:0] w_count_next;

   // Change detection and write/drop decision.
   // A full FIFO still accepts a write when a read frees a slot on the same edge.
   always_comb begin
      w_chg  = (Out_Reg_In != r_last_val);
      w_rd   = rd_if.Rd_Valid & rd_if.Rd_Ready;
      w_full = (w_count == C_DEPTH);
      w_wr   = ~rst & w_chg & (~w_full | w_rd);
      w_drop = w_chg & w_full & ~w_rd;
   end

   retreo_sync_fifo #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_fifo (
      .clk          (clk),
      .rst          (rst),
      .i_wr         (w_wr),
      .i_wr_data    (Out_Reg_In),
      .i_rd         (w_rd),
      .o_rd_data    (rd_if.Rd_Data),
      .o_valid      (rd_if.Rd_Valid),
      .o_count      (w_count),
      .o_count_next (w_count_next)
   );

   // Track the last observed value even when the write is dropped, so a lost value is never re-detected.
   always_ff @(posedge clk) begin
      if (rst)
         r_last_val <= '0;
      else if (w_chg)
         r_last_val <= Out_Reg_In;
   end

   // The stall request is registered from the next occupancy. It therefore mirrors the current Count with no input-to-output path.
   always_ff @(posedge clk) begin
      if (rst)
         r_stall <= 1'b0;
      else
         r_stall <= (w_count_next >= C_THRESH);
   end

   // Sticky overflow flag. Only reset clears it.
   always_ff @(posedge clk) begin
      if (rst)
         r_overflow <= 1'b0;
      else if (w_drop)
         r_overflow <= 1'b1;
   end

   assign Stall_Req = r_stall;
   assign Overflow  = r_overflow;
   assign Count     = w_count;

endmodule

// File: tb/tb_retreo_out_fifo.sv
// Scoreboard bench for retreo_out_fifo.
// The stimulus thread pushes the hand-derived expected read data into a queue.
// A negedge monitor pops the queue and compares on every accepted read.
module tb_retreo_out_fifo;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] out_reg;
   logic        stall;
   logic [3:0]  count;
   logic        ovf;
   logic [15:0] exp_q [$];
   logic [15:0] e;
   int          n_checks = 0;
   int          n_err    = 0;

   retreo_out_fifo_if rd_if ();

   retreo_out_fifo #(
      .DEPTH        (8),
      .STALL_MARGIN (2)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .Out_Reg_In (out_reg),
      .Stall_Req  (stall),
      .rd_if      (rd_if),
      .Count      (count),
      .Overflow   (ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Apply inputs, let one rising edge pass, then settle just after it.
   task automatic drive(input logic [15:0] v, input logic rdy);
      out_reg        = v;
      rd_if.Rd_Ready = rdy;
      @(posedge clk);
      #1;
   endtask

   // Check every read that the next rising edge will accept.
   always @(negedge clk) begin
      if (!rst && rd_if.Rd_Valid && rd_if.Rd_Ready) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL rd_unexpected: got %0h expected no data", rd_if.Rd_Data);
         end else begin
            e = exp_q.pop_front();
            chk("rd_data", {16'h0, rd_if.Rd_Data}, {16'h0, e});
         end
      end
   end

   initial begin
      rst            = 1'b1;
      out_reg        = 16'h0000;
      rd_if.Rd_Ready = 1'b0;

      // 1: reset, then hold zero. Zero is never captured.
      drive(16'h0000, 1'b0);
      drive(16'h0000, 1'b0);
      rst = 1'b0;
      for (int i = 0; i < 5; i++) drive(16'h0000, 1'b0);
      chk("t1_count", 32'(count), 32'd0);
      chk("t1_valid", 32'(rd_if.Rd_Valid), 32'd0);
      chk("t1_stall", 32'(stall), 32'd0);
      chk("t1_ovf",   32'(ovf),   32'd0);

      // 2: two changes are queued, then drained in order.
      exp_q.push_back(16'h0004); drive(16'h0004, 1'b0);
      chk("t2_valid1", 32'(rd_if.Rd_Valid), 32'd1);
      exp_q.push_back(16'h0008); drive(16'h0008, 1'b0);
      chk("t2_count", 32'(count), 32'd2);
      drive(16'h0008, 1'b1);
      drive(16'h0008, 1'b1);
      chk("t2_valid0", 32'(rd_if.Rd_Valid), 32'd0);
      chk("t2_count0", 32'(count), 32'd0);
      drive(16'h0008, 1'b1);
      chk("t2_nounder", 32'(count), 32'd0);

      // 3: holding a value produces exactly one entry.
      exp_q.push_back(16'h0004);
      for (int i = 0; i < 10; i++) drive(16'h0004, 1'b0);
      chk("t3_count", 32'(count), 32'd1);
      drive(16'h0004, 1'b1);
      chk("t3_drained", 32'(count), 32'd0);

      // 4: Stall_Req asserts in the same cycle Count reaches 6.
      for (int i = 0; i < 6; i++) begin
         exp_q.push_back(16'h0011 + 16'(i));
         drive(16'h0011 + 16'(i), 1'b0);
         if (i == 4) chk("t4_stall_at5", 32'(stall), 32'd0);
      end
      chk("t4_count", 32'(count), 32'd6);
      chk("t4_stall", 32'(stall), 32'd1);

      // 5: fill to 8, the ninth value is dropped, then drain.
      exp_q.push_back(16'h0017); drive(16'h0017, 1'b0);
      exp_q.push_back(16'h0018); drive(16'h0018, 1'b0);
      chk("t5_count8", 32'(count), 32'd8);
      chk("t5_ovf0",   32'(ovf),   32'd0);
      drive(16'h0019, 1'b0);
      chk("t5_count_full", 32'(count), 32'd8);
      chk("t5_ovf1",       32'(ovf),   32'd1);
      for (int i = 0; i < 8; i++) begin
         drive(16'h0019, 1'b1);
         chk("t5_drain_count", 32'(count), 32'(7 - i));
         chk("t5_drain_stall", 32'(stall), (7 - i) >= 6 ? 32'd1 : 32'd0);
      end
      chk("t5_valid0",   32'(rd_if.Rd_Valid), 32'd0);
      chk("t5_ovf_stay", 32'(ovf),            32'd1);
      chk("t5_q_empty",  32'(exp_q.size()),   32'd0);

      // 6: full with a simultaneous read accepts the write, then reset mid-burst.
      rst = 1'b1;
      drive(16'h0000, 1'b0);
      rst = 1'b0;
      chk("t6_ovf_clr", 32'(ovf), 32'd0);
      for (int i = 0; i < 8; i++) begin
         exp_q.push_back(16'h0021 + 16'(i));
         drive(16'h0021 + 16'(i), 1'b0);
      end
      chk("t6_full", 32'(count), 32'd8);
      exp_q.push_back(16'h0029); drive(16'h0029, 1'b1);
      chk("t6_count_rw", 32'(count), 32'd8);
      chk("t6_ovf_rw",   32'(ovf),   32'd0);
      exp_q.push_back(16'h002A); drive(16'h002A, 1'b1);
      chk("t6_count_rw2", 32'(count), 32'd8);
      rst = 1'b1;
      drive(16'h002B, 1'b1);
      exp_q.delete();
      chk("t6_rst_count", 32'(count),          32'd0);
      chk("t6_rst_valid", 32'(rd_if.Rd_Valid), 32'd0);
      chk("t6_rst_stall", 32'(stall),          32'd0);
      rst = 1'b0;
      drive(16'h0000, 1'b0);
      chk("t6_zero_ignored", 32'(count), 32'd0);
      exp_q.push_back(16'h0055); drive(16'h0055, 1'b0);
      chk("t6_post_count", 32'(count), 32'd1);
      drive(16'h0055, 1'b1);
      drive(16'h0055, 1'b0);
      chk("t6_final_count", 32'(count),        32'd0);
      chk("t6_final_q",     32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule

// File: doc/retreo_out_fifo.md
Name: retreo_out_fifo

Overview:
- Downstream consumer of the ReTReO core's 16-bit Out_Reg.
- Detects each change of Out_Reg and pushes the new value into a small first-word-fall-through (FWFT) FIFO, drained by a valid/ready reader (UART or debug host).
- Generates Stall_Req, which is wired back to the core's Override_Stall input so the core halts before output values are lost.

Parameters:
- DEPTH, 8, number of FIFO entries; power of two, at least 4.
- ADDR_W, 3, log2(DEPTH).
- STALL_MARGIN, 2, Stall_Req asserts when occupancy is at least DEPTH-STALL_MARGIN; range 1 to DEPTH-1.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- Out_Reg_In  in  16  core Out_Reg value.
- Stall_Req  out  1  registered stall request, connected to the core's Override_Stall.
- Rd_Valid  out  1  FIFO non-empty.
- Rd_Ready  in  1  reader accepts Rd_Data this cycle.
- Rd_Data  out  16  head entry; valid when Rd_Valid=1.
- Count  out  ADDR_W+1  current occupancy, 0 to DEPTH.
- Overflow  out  1  sticky flag: a change was dropped.

Behaviour:
- Reset (rst=1 at an edge):
  - rd_ptr=0, wr_ptr=0, Count=0, last_val=16'h0000.
  - Rd_Valid=0, Stall_Req=0, Overflow=0.
  - Rd_Data is don't-care; memory contents are not cleared.
  - Reset mid-operation discards all entries with no partial drain. rst has priority over every other event in that cycle.
- Change detect:
  - chg = (Out_Reg_In != last_val).
  - On every edge with chg=1, last_val <= Out_Reg_In, whether or not the write is accepted. A dropped value is therefore not re-detected.
  - Consequence: 16'h0000 is never captured immediately after reset; a value is captured only when it differs from the previous one.
- Read: rd = Rd_Valid & Rd_Ready. On rd, rd_ptr increments and wraps modulo DEPTH.
- Write: wr = chg & (Count<DEPTH | rd). On wr, mem[wr_ptr] <= Out_Reg_In and wr_ptr increments, wrapping modulo DEPTH.
- Full with a simultaneous read: the write is accepted and Count stays at DEPTH.
- Drop: chg & Count==DEPTH & !rd. No write occurs and Overflow <= 1. Overflow is cleared only by rst.
- Count update: Count <= Count + wr - rd. Simultaneous wr and rd leaves Count unchanged.
- Rd_Valid = (Count != 0), derived from registered state.
- Rd_Data = mem[rd_ptr], combinational from registered state (FWFT).
- Empty with a simultaneous write: no bypass. Data appears at Rd_Data with Rd_Valid=1 in the cycle after the write edge.
- Latency: a value present at edge k is readable from cycle k+1 onward.
- Rd_Ready while Rd_Valid=0 has no effect; Count never underflows.
- Stall_Req:
  - Register updated at each edge: Stall_Req <= (Count_next >= DEPTH-STALL_MARGIN).
  - It therefore always equals (Count >= DEPTH-STALL_MARGIN) in the same cycle, with no combinational path from any input.
  - Deasserts in the cycle after reads bring occupancy below the threshold.
- Pointer wrap: pointers are ADDR_W bits wide. Full and empty are distinguished by Count, not by pointer comparison.

Decomposition:
- Shared package retreo_pkg holds:
  - WORD_W = 16 (ReTReO register width).
  - Default FIFO depth constant.
- One sub-module: retreo_sync_fifo, holding pointers, memory, Count, and the FWFT read.
- Top level retreo_out_fifo holds change detect, last_val, the drop/Overflow logic, and Stall_Req.

Test Plan:
1. Reset, hold Out_Reg_In=16'h0000 for 5 cycles -> Count=0, Rd_Valid=0, Stall_Req=0.
2. Out_Reg_In=16'h0004 then 16'h0008 on consecutive cycles, Rd_Ready=0 -> Count=2. Then Rd_Ready=1 -> Rd_Data 16'h0004, then 16'h0008, then Rd_Valid=0.
3. Hold 16'h0004 for 10 cycles -> exactly one entry, Count=1.
4. Drive 6 distinct values (defaults: DEPTH=8, STALL_MARGIN=2), Rd_Ready=0 -> Stall_Req=1 in the same cycle Count=6.
5. Continue to 9 distinct values, Rd_Ready=0 -> Count=8, Overflow=1, 9th value absent. Then drain -> 8 values in order, Overflow stays 1.
6. Full FIFO, new value with Rd_Ready=1 on the same edge -> Count stays 8, new value accepted, Overflow stays 0. Assert rst mid-burst -> next cycle Count=0, Rd_Valid=0, Stall_Req=0.
